// File: rtl/wb_regfile_stage.sv
// rtl/wb_regfile_stage.sv - write-back select, 32x32 register file with write-first bypass and retired-write counter
module wb_regfile_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              WB_RegWrite,
    input  logic [1:0]        WB_DatatoReg,
    input  logic [DATA_W-1:0] WB_mem_data_out,
    input  logic [DATA_W-1:0] WB_ALU_result,
    input  logic [DATA_W-1:0] WB_pc_4,
    input  logic [DATA_W-1:0] WB_lui_32,
    input  logic [ADDR_W-1:0] WB_register_write_address,
    input  logic [ADDR_W-1:0] ID_rs_addr,
    input  logic [ADDR_W-1:0] ID_rt_addr,
    output logic [DATA_W-1:0] ID_rs_data,
    output logic [DATA_W-1:0] ID_rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] WB_write_data,
    output logic              wb_commit,
    output logic [CNT_W-1:0]  wb_count
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_wdata;
    logic              w_commit;

    always_comb begin
        w_wdata = WB_ALU_result;
        case (WB_DatatoReg)
            2'b00:   w_wdata = WB_ALU_result;
            2'b01:   w_wdata = WB_mem_data_out;
            2'b10:   w_wdata = WB_pc_4;
            default: w_wdata = WB_lui_32;
        endcase
    end

    // Reset and the freeze both suppress commit, which also kills the bypass path.
    assign w_commit = WB_RegWrite & cpu_en & ~reset &
                      (WB_register_write_address != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[WB_register_write_address] <= w_wdata;
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        ID_rs_data = r_regs[ID_rs_addr];
        if (ID_rs_addr == '0) begin
            ID_rs_data = '0;
        end else if (w_commit && (ID_rs_addr == WB_register_write_address)) begin
            ID_rs_data = w_wdata;
        end
    end

    always_comb begin
        ID_rt_data = r_regs[ID_rt_addr];
        if (ID_rt_addr == '0) begin
            ID_rt_data = '0;
        end else if (w_commit && (ID_rt_addr == WB_register_write_address)) begin
            ID_rt_data = w_wdata;
        end
    end

    assign dbg_data      = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
    assign WB_write_data = w_wdata;
    assign wb_commit     = w_commit;
    assign wb_count      = r_count;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb/tb_wb_regfile_stage.sv - directed vector bench for wb_regfile_stage
`timescale 1ns/1ps
module tb_wb_regfile_stage;
    logic        clk = 1'b0;
    logic        reset, cpu_en, we;
    logic [1:0]  sel;
    logic [31:0] mem, alu, pc4, lui;
    logic [4:0]  wa, rs, rt, dbg;
    logic [31:0] rs_d, rt_d, dbg_d, wd;
    logic        cm;
    logic [31:0] cnt;
    logic [31:0] rs_d4, rt_d4, dbg_d4, wd4;
    logic        cm4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile_stage dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .WB_RegWrite(we), .WB_DatatoReg(sel),
        .WB_mem_data_out(mem), .WB_ALU_result(alu), .WB_pc_4(pc4), .WB_lui_32(lui),
        .WB_register_write_address(wa), .ID_rs_addr(rs), .ID_rt_addr(rt),
        .ID_rs_data(rs_d), .ID_rt_data(rt_d), .dbg_addr(dbg), .dbg_data(dbg_d),
        .WB_write_data(wd), .wb_commit(cm), .wb_count(cnt)
    );

    wb_regfile_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .WB_RegWrite(we), .WB_DatatoReg(sel),
        .WB_mem_data_out(mem), .WB_ALU_result(alu), .WB_pc_4(pc4), .WB_lui_32(lui),
        .WB_register_write_address(wa), .ID_rs_addr(rs), .ID_rt_addr(rt),
        .ID_rs_data(rs_d4), .ID_rt_data(rt_d4), .dbg_addr(dbg), .dbg_data(dbg_d4),
        .WB_write_data(wd4), .wb_commit(cm4), .wb_count(cnt4)
    );

    typedef struct {
        logic        rst, en, we;
        logic [1:0]  sel;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [4:0]  rs, rt, dbg;
        logic [31:0] e_rs, e_rt, e_dbg, e_wd;
        logic        e_cm;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic w, input logic [1:0] s,
                         input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        reset = r; cpu_en = e; we = w; sel = s; wa = a; alu = d; rs = ra; rt = rb; dbg = rd;
    endtask

    initial begin
        mem = 32'hAAAA_0000; pc4 = 32'h0040_0008; lui = 32'hBEEF_0000;
        //          rst en we sel    wa  alu            rs  rt  dbg  e_rs           e_rt           e_dbg          e_wd           cm cnt
        vecs[0]  = '{1, 1, 1, 2'b00, 5,  32'h1,         5,  5,  5,   32'h0,         32'h0,         32'h0,         32'h1,         0, 0};
        vecs[1]  = '{0, 1, 1, 2'b00, 5,  32'h12345678,  5,  6,  5,   32'h12345678,  32'h0,         32'h0,         32'h12345678,  1, 0};
        vecs[2]  = '{0, 1, 0, 2'b00, 5,  32'h0,         6,  5,  5,   32'h0,         32'h12345678,  32'h12345678,  32'h0,         0, 1};
        vecs[3]  = '{0, 1, 1, 2'b01, 31, 32'h0,         31, 31, 31,  32'hAAAA0000,  32'hAAAA0000,  32'h0,         32'hAAAA0000,  1, 1};
        vecs[4]  = '{0, 1, 1, 2'b10, 31, 32'h0,         31, 31, 31,  32'h00400008,  32'h00400008,  32'hAAAA0000,  32'h00400008,  1, 2};
        vecs[5]  = '{0, 1, 1, 2'b11, 31, 32'h0,         31, 31, 31,  32'hBEEF0000,  32'hBEEF0000,  32'h00400008,  32'hBEEF0000,  1, 3};
        vecs[6]  = '{0, 1, 0, 2'b11, 31, 32'h0,         31, 0,  31,  32'hBEEF0000,  32'h0,         32'hBEEF0000,  32'hBEEF0000,  0, 4};
        vecs[7]  = '{0, 1, 1, 2'b00, 0,  32'hFFFFFFFF,  0,  0,  0,   32'h0,         32'h0,         32'h0,         32'hFFFFFFFF,  0, 4};
        vecs[8]  = '{0, 1, 0, 2'b00, 0,  32'h0,         0,  0,  0,   32'h0,         32'h0,         32'h0,         32'h0,         0, 4};
        vecs[9]  = '{0, 0, 1, 2'b00, 7,  32'h55,        7,  7,  7,   32'h0,         32'h0,         32'h0,         32'h55,        0, 4};
        vecs[10] = '{0, 0, 0, 2'b00, 7,  32'h55,        7,  7,  7,   32'h0,         32'h0,         32'h0,         32'h55,        0, 4};
        vecs[11] = '{0, 1, 1, 2'b00, 7,  32'h55,        7,  5,  7,   32'h55,        32'h12345678,  32'h0,         32'h55,        1, 4};
        vecs[12] = '{1, 1, 1, 2'b00, 3,  32'h99,        3,  7,  7,   32'h0,         32'h55,        32'h55,        32'h99,        0, 5};
        vecs[13] = '{0, 1, 0, 2'b00, 3,  32'h0,         3,  7,  5,   32'h0,         32'h0,         32'h0,         32'h0,         0, 0};

        drive(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        // every address reads 0 on all ports after reset
        for (int a = 0; a < 32; a++) begin
            drive(0, 1, 0, 2'b00, 0, 0, 5'(a), 5'(31 - a), 5'(a));
            #4;
            check("rst_rs", a, rs_d, 0);
            check("rst_rt", a, rt_d, 0);
            check("rst_dbg", a, dbg_d, 0);
            @(negedge clk);
        end
        check("rst_cnt", 0, cnt, 0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].sel, vecs[i].wa, vecs[i].alu,
                  vecs[i].rs, vecs[i].rt, vecs[i].dbg);
            #4;
            check("rs", i, rs_d, vecs[i].e_rs);
            check("rt", i, rt_d, vecs[i].e_rt);
            check("dbg", i, dbg_d, vecs[i].e_dbg);
            check("wdata", i, wd, vecs[i].e_wd);
            check("commit", i, 32'(cm), 32'(vecs[i].e_cm));
            check("count", i, cnt, vecs[i].e_cnt);
            @(negedge clk);
        end

        // counter wrap on the 4-bit build
        drive(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            drive(0, 1, 1, 2'b00, 1, 32'(k), 1, 1, 1);
            @(negedge clk);
        end
        drive(0, 1, 0, 2'b00, 1, 0, 1, 1, 1);
        #4;
        check("cnt4_max", 0, 32'(cnt4), 15);
        check("dbg_last", 0, dbg_d, 14);
        @(negedge clk);
        drive(0, 1, 1, 2'b00, 2, 32'h77, 2, 1, 2);
        @(negedge clk);
        drive(0, 1, 0, 2'b00, 2, 0, 2, 1, 2);
        #4;
        check("cnt4_wrap", 0, 32'(cnt4), 0);
        check("cnt32_16", 0, cnt, 16);
        check("dbg_r2", 0, dbg_d, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
Write-back stage and general register file of the 5-stage MIPS pipeline. It sits downstream of the MEM/WB pipeline latch and consumes its WB_* outputs. It selects the write-back value and commits it to a 32x32 register file. It also serves the ID stage's two read ports with same-cycle write-through bypass, plus a debug read port and a retired-write counter.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register address width (2**ADDR_W registers)
CNT_W, 32, width of retired-write counter

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
cpu_en  in  1  global pipeline enable; 0 freezes all state
WB_RegWrite  in  1  write-back enable from MEM/WB latch
WB_DatatoReg  in  2  write-back source select
WB_mem_data_out  in  DATA_W  load data
WB_ALU_result  in  DATA_W  ALU result
WB_pc_4  in  DATA_W  PC+4 (link value for jal)
WB_lui_32  in  DATA_W  upper-immediate value
WB_register_write_address  in  ADDR_W  destination register
ID_rs_addr  in  ADDR_W  read port A address
ID_rt_addr  in  ADDR_W  read port B address
ID_rs_data  out  DATA_W  read port A data
ID_rt_data  out  DATA_W  read port B data
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data (no bypass)
WB_write_data  out  DATA_W  selected write-back value (for forwarding units)
wb_commit  out  1  high in cycles where a register write commits
wb_count  out  CNT_W  number of committed register writes since reset

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Source select, combinational:
  - WB_DatatoReg 2'b00 -> WB_ALU_result
  - 2'b01 -> WB_mem_data_out
  - 2'b10 -> WB_pc_4
  - 2'b11 -> WB_lui_32
- wb_commit = WB_RegWrite & cpu_en & ~reset & (WB_register_write_address != 0).
- Register write: on posedge clk, if wb_commit then reg[WB_register_write_address] <= WB_write_data. Writes to $0 are discarded.
- $0 always reads 0 on every port, regardless of bypass.
- Read ports A/B, combinational:
  - If addr == 0, output 0.
  - Else if wb_commit and addr == WB_register_write_address, output WB_write_data (write-first bypass; the ID stage needs no extra half-cycle trick).
  - Else output reg[addr].
- dbg_data = reg[dbg_addr] with no bypass; it shows the new value the cycle after commit.
- wb_count increments by 1 on each posedge where wb_commit=1 and wraps at 2**CNT_W-1 -> 0.
- cpu_en=0: no register write, no counter change, no bypass. Reads return stored contents.
- Reset, on posedge with reset=1:
  - All 32 registers clear to 0 and wb_count clears to 0.
  - A write presented in the same cycle is dropped (reset wins).
  - Mid-operation reset behaves identically.
- Reset values: ID_rs_data, ID_rt_data and dbg_data read 0 after reset until written. wb_commit is 0 while reset=1. WB_write_data is combinational and has no reset value.
- Latency: write visible on read ports in the same cycle via bypass, and from stored state on the next cycle. Debug port latency is 1 cycle.
- Simultaneous: both read ports may target the write address. Both receive the bypassed value.

Test Plan:
- Reset, then read all 32 addresses on A, B and dbg -> all 0; wb_count=0.
- Write ALU 0x12345678 to $5 (DatatoReg=00, RegWrite=1, cpu_en=1) with ID_rs_addr=5 the same cycle -> ID_rs_data=0x12345678 in that cycle. dbg_addr=5 reads 0 that cycle and 0x12345678 next cycle. wb_count=1.
- Sweep DatatoReg 01/10/11 with mem=0xAAAA0000, pc_4=0x00400008, lui=0xBEEF0000 into $31 -> $31 holds each value in turn; WB_write_data matches each select.
- Write 0xFFFFFFFF to $0 -> $0 reads 0 on A, B and dbg; wb_commit=0; wb_count unchanged.
- cpu_en=0 with RegWrite=1, addr=$7, data=0x55 -> $7 unchanged, no bypass, count unchanged. Raise cpu_en -> commit occurs.
- Assert reset in the same cycle as a write of 0x99 to $3 after prior writes -> $3=0, all regs 0, wb_count=0. Also force wb_count=2**CNT_W-1 (CNT_W=4 build) plus one commit -> wraps to 0.
